// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares one bus between the instruction and data ports.
// At most one bus transaction is in flight. Data wins a tie unless it also
// won the previous grant, so neither requester can starve the other.
module cpu_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    logic              owner_data;
    logic              last_data;
    logic              lat_wr;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic grant_data;
    logic grant_inst;
    logic done;

    // Pick a winner (data priority, alternating on a tie) and spot completion
    always_comb begin
        grant_data = 1'b0;
        grant_inst = 1'b0;
        done       = 1'b0;
        if (state == IDLE) begin
            grant_data = data_req && (!inst_req || !last_data);
            grant_inst = inst_req && !grant_data;
        end
        if (state == ADDR)
            done = bus_addr_ok && bus_data_ok;
        else if (state == DATA)
            done = bus_data_ok;
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = done && !owner_data;
    assign data_data_ok = done && owner_data;
    assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
    assign data_rdata   = data_data_ok ? bus_rdata : '0;
    assign bus_req      = (state == ADDR);
    assign busy         = (state != IDLE);
    assign bus_wr       = lat_wr;
    assign bus_size     = lat_size;
    assign bus_addr     = lat_addr;
    assign bus_wdata    = lat_wdata;

    // Transaction FSM: latch the winner's request, then walk it through the bus handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner_data <= 1'b0;
            last_data  <= 1'b0;
            lat_wr     <= 1'b0;
            lat_size   <= 2'b00;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data || grant_inst) begin
                        owner_data <= grant_data;
                        last_data  <= grant_data;
                        lat_wr     <= grant_data && data_wr;
                        lat_size   <= grant_data ? data_size : 2'b10;
                        lat_addr   <= grant_data ? data_addr : inst_addr;
                        lat_wdata  <= grant_data ? data_wdata : '0;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus_addr_ok)
                        state <= bus_data_ok ? IDLE : DATA;
                end
                DATA: begin
                    if (bus_data_ok)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: cycle-by-cycle directed vectors for cpu_bus_arbiter,
// plus a hand-written sequence for reset in the middle of a transaction.
module tb_cpu_bus_arbiter;

    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] DA = 32'h8000_1000;
    localparam logic [31:0] WD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy;

    int total  = 0;
    int passed = 0;

    // ctl = {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, bus_req, busy}
    typedef struct {
        logic        ir;
        logic        dr;
        logic        baok;
        logic        bdok;
        logic [31:0] rd;
        logic [5:0]  ctl;
        logic [31:0] ird;
        logic [31:0] drd;
        logic        care;
        logic        fwr;
        logic [31:0] faddr;
        logic [31:0] fwd;
    } vec_t;

    vec_t vecs[$];

    cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ir, dr, baok, bdok, input logic [31:0] rd,
                                input logic [5:0] ctl, input logic [31:0] ird, drd,
                                input logic care, fwr, input logic [31:0] faddr, fwd);
        vec_t v;
        v.ir = ir; v.dr = dr; v.baok = baok; v.bdok = bdok; v.rd = rd;
        v.ctl = ctl; v.ird = ird; v.drd = drd;
        v.care = care; v.fwr = fwr; v.faddr = faddr; v.fwd = fwd;
        return v;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    function automatic logic [159:0] all_outputs();
        return {inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
                bus_req, bus_wr, bus_size, bus_addr, bus_wdata, busy};
    endfunction

    task automatic apply_stimulus(input vec_t v);
        inst_req    = v.ir;
        data_req    = v.dr;
        bus_addr_ok = v.baok;
        bus_data_ok = v.bdok;
        bus_rdata   = v.rd;
    endtask

    task automatic check_output(input int idx, input vec_t v);
        check($sformatf("vec%0d_ctl", idx),
              {88'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, bus_req, busy,
               inst_rdata, data_rdata},
              {88'd0, v.ctl, v.ird, v.drd});
        if (v.care)
            check($sformatf("vec%0d_fields", idx),
                  {91'd0, bus_wr, bus_size, bus_addr, bus_wdata},
                  {91'd0, v.fwr, 2'b10, v.faddr, v.fwd});
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
        inst_addr = IA; data_addr = DA; data_wdata = WD; data_wr = 1'b1; data_size = 2'b10;

        // Instruction fetch alone, bus_addr_ok at cycle 2, data at cycle 4
        vecs.push_back(mk(1,0,0,0,32'h0,        6'b100000, 32'h0, 32'h0, 0,0,IA,0));
        vecs.push_back(mk(0,0,0,0,32'h0,        6'b000011, 32'h0, 32'h0, 1,0,IA,0));
        vecs.push_back(mk(0,0,1,0,32'h0,        6'b000011, 32'h0, 32'h0, 1,0,IA,0));
        vecs.push_back(mk(0,0,0,0,32'h0,        6'b000001, 32'h0, 32'h0, 1,0,IA,0));
        vecs.push_back(mk(0,0,0,1,32'h24080001, 6'b001001, 32'h24080001, 32'h0, 0,0,IA,0));
        // Stray bus_data_ok while idle is ignored
        vecs.push_back(mk(0,0,0,1,32'hCAFEF00D, 6'b000000, 32'h0, 32'h0, 0,0,IA,0));
        vecs.push_back(mk(0,0,0,0,32'h0,        6'b000000, 32'h0, 32'h0, 0,0,IA,0));
        // Both request, last owner inst: data write wins, inst follows after completion
        vecs.push_back(mk(1,1,0,0,32'h0,        6'b010000, 32'h0, 32'h0, 0,0,IA,0));
        vecs.push_back(mk(1,0,0,0,32'h0,        6'b000011, 32'h0, 32'h0, 1,1,DA,WD));
        vecs.push_back(mk(1,0,1,0,32'h0,        6'b000011, 32'h0, 32'h0, 1,1,DA,WD));
        vecs.push_back(mk(1,0,0,1,32'h12345678, 6'b000101, 32'h0, 32'h12345678, 1,1,DA,WD));
        vecs.push_back(mk(1,0,0,0,32'h0,        6'b100000, 32'h0, 32'h0, 0,0,IA,0));
        // Address and data accepted together: two-cycle transaction
        vecs.push_back(mk(0,0,1,1,32'hA5A5A5A5, 6'b001011, 32'hA5A5A5A5, 32'h0, 1,0,IA,0));
        vecs.push_back(mk(0,0,0,0,32'h0,        6'b000000, 32'h0, 32'h0, 0,0,IA,0));
        // Continuous contention: data, inst, data, inst
        vecs.push_back(mk(1,1,0,0,32'h0,        6'b010000, 32'h0, 32'h0, 0,0,IA,0));
        vecs.push_back(mk(1,1,1,1,32'h11111111, 6'b000111, 32'h0, 32'h11111111, 1,1,DA,WD));
        vecs.push_back(mk(1,1,0,0,32'h0,        6'b100000, 32'h0, 32'h0, 0,0,IA,0));
        vecs.push_back(mk(1,1,1,1,32'h22222222, 6'b001011, 32'h22222222, 32'h0, 1,0,IA,0));
        vecs.push_back(mk(1,1,0,0,32'h0,        6'b010000, 32'h0, 32'h0, 0,0,IA,0));
        vecs.push_back(mk(1,1,1,1,32'h33333333, 6'b000111, 32'h0, 32'h33333333, 1,1,DA,WD));
        vecs.push_back(mk(1,1,0,0,32'h0,        6'b100000, 32'h0, 32'h0, 0,0,IA,0));
        vecs.push_back(mk(1,1,1,1,32'h44444444, 6'b001011, 32'h44444444, 32'h0, 1,0,IA,0));
        vecs.push_back(mk(0,0,0,0,32'h0,        6'b000000, 32'h0, 32'h0, 0,0,IA,0));

        #3;
        check("reset_state", all_outputs(), 160'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #1;
            check_output(i, vecs[i]);
        end

        // Reset in DATA, then a late bus_data_ok must be ignored
        @(negedge clk);
        data_req = 1; inst_req = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
        @(negedge clk);
        data_req = 0; bus_addr_ok = 1;
        @(negedge clk);
        bus_addr_ok = 0;
        #1;
        check("in_data_before_rst", {159'd0, busy}, 160'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", all_outputs(), 160'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_data_ok = 1; bus_rdata = 32'h5555AAAA;
        #1;
        check("late_data_ok_ignored", all_outputs(), 160'd0);
        @(negedge clk);
        #1;
        check("idle_after_rst", all_outputs(), 160'd0);

        // First edge after reset grants; last owner is back to inst so data wins
        bus_data_ok = 0; bus_rdata = '0;
        inst_req = 1; data_req = 1;
        #1;
        check("grant_after_rst", {158'd0, inst_addr_ok, data_addr_ok}, 160'd1);
        @(negedge clk);
        inst_req = 0; data_req = 0;
        #1;
        check("addr_after_rst", {126'd0, bus_req, busy, bus_addr}, {126'd0, 2'b11, DA});

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
